// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between fetch and load/store.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [3:0] BYTE_EN_ALL = 4'hF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between fetch and data ports; data has priority, bounded by a burst limit.
// Optional stall counters are enabled with `define MEM_ARB_PERF_CNT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LATENCY    = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_byte_en,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_we,
    output logic [3:0]        m_byte_en,
    input  logic [DATA_W-1:0] m_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_i_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    localparam int          BW        = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
    localparam logic [2:0]  LAT_INIT  = 3'(MEM_LATENCY);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    owner_t            r_owner;
    logic [BW-1:0]     r_burst_cnt;
    logic [2:0]        r_lat_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [3:0]        r_m_byte_en;
    logic              r_m_we;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_valid;
    logic              r_d_valid;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_capture;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = (w_grant_d || w_grant_i) ? WAIT : IDLE;
            WAIT:    w_state_nxt = w_capture ? RESP : WAIT;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM decode: grant selection in IDLE (fetch forced once the data burst limit is hit), capture in WAIT
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && !(i_req && (r_burst_cnt == BURST_MAX))) begin
                    w_grant_d = 1'b1;
                end else begin
                    w_grant_i = i_req;
                end
            end
            WAIT:    w_capture = (r_lat_cnt == 3'd1);
            RESP:    w_capture = 1'b0;
            default: w_capture = 1'b0;
        endcase
    end

    // Transaction latches, latency countdown, read-data capture and completion pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner     <= OWN_INSTR;
            r_lat_cnt   <= 3'd0;
            r_we        <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_m_byte_en <= 4'h0;
            r_m_we      <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_m_we    <= 1'b0;
            if (w_grant_d) begin
                r_owner     <= OWN_DATA;
                r_m_addr    <= d_addr;
                r_m_wdata   <= d_wdata;
                r_m_byte_en <= d_byte_en;
                r_we        <= d_we;
                r_m_we      <= d_we;
                r_lat_cnt   <= LAT_INIT;
            end else if (w_grant_i) begin
                r_owner     <= OWN_INSTR;
                r_m_addr    <= i_addr;
                r_m_wdata   <= '0;
                r_m_byte_en <= BYTE_EN_ALL;
                r_we        <= 1'b0;
                r_lat_cnt   <= LAT_INIT;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end else begin
                r_lat_cnt <= r_lat_cnt;
            end
            if (w_capture) begin
                if (r_owner == OWN_DATA) begin
                    r_d_rdata <= r_we ? '0 : m_rdata;
                    r_d_valid <= 1'b1;
                end else begin
                    r_i_rdata <= m_rdata;
                    r_i_valid <= 1'b1;
                end
            end
        end
    end

    // Saturating count of consecutive data grants taken while fetch is waiting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (w_grant_d && i_req) begin
            if (r_burst_cnt != BURST_MAX) begin
                r_burst_cnt <= r_burst_cnt + BW'(1);
            end
        end else if (w_grant_d || w_grant_i) begin
            r_burst_cnt <= '0;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] r_perf_i_stall;
    logic [31:0] r_perf_d_stall;

    // Stall counters: cycles with a pending request and no completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_i_stall <= 32'd0;
            r_perf_d_stall <= 32'd0;
        end else begin
            if (i_req && !r_i_valid) begin
                r_perf_i_stall <= sat_inc32(r_perf_i_stall);
            end
            if (d_req && !r_d_valid) begin
                r_perf_d_stall <= sat_inc32(r_perf_d_stall);
            end
        end
    end

    assign perf_i_stall = r_perf_i_stall;
    assign perf_d_stall = r_perf_d_stall;
`endif

    assign i_rdata   = r_i_rdata;
    assign i_valid   = r_i_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_we      = r_m_we;
    assign m_byte_en = r_m_byte_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MEM_LATENCY = 1, MAX_DATA_BURST = 4.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_en;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [3:0]  m_byte_en;
    logic [31:0] m_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_stall;
    logic [31:0] perf_d_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MAX_DATA_BURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_valid(d_valid),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_byte_en(m_byte_en),
        .m_rdata(m_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_i_stall(perf_i_stall), .perf_d_stall(perf_d_stall)
`endif
    );

    always #5 clk = ~clk;

    // Asynchronous-read memory model with a few fixed words
    always_comb begin
        case (m_addr)
            32'h0000_0010: m_rdata = 32'h0050_0093;
            32'h0000_0100: m_rdata = 32'h1234_5678;
            32'h0000_0300: m_rdata = 32'hCAFE_0300;
            default:       m_rdata = 32'h0BAD_0BAD;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int got_order [$];
    int got_cycle [$];

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_byte_en = 4'h0;
        repeat (3) tick();
        check_val("rst_i_valid", {31'd0, i_valid}, 32'd0);
        check_val("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check_val("rst_m_we", {31'd0, m_we}, 32'd0);
        check_val("rst_m_addr", m_addr, 32'h0);
        check_val("rst_m_be", {28'd0, m_byte_en}, 32'h0);
        check_val("rst_i_rdata", i_rdata, 32'h0);
        rst_n = 1'b1;

        // Fetch only: request at cycle 0, valid only at cycle 2
        i_req = 1'b1; i_addr = 32'h10;
        check_val("f_c0_valid", {31'd0, i_valid}, 32'd0);
        tick();
        check_val("f_c1_valid", {31'd0, i_valid}, 32'd0);
        check_val("f_c1_m_addr", m_addr, 32'h10);
        check_val("f_c1_m_we", {31'd0, m_we}, 32'd0);
        check_val("f_c1_m_be", {28'd0, m_byte_en}, 32'hF);
        tick();
        check_val("f_c2_valid", {31'd0, i_valid}, 32'd1);
        check_val("f_c2_rdata", i_rdata, 32'h0050_0093);
        check_val("f_c2_d_valid", {31'd0, d_valid}, 32'd0);
        check_val("f_c2_m_we", {31'd0, m_we}, 32'd0);
        i_req = 1'b0;
        tick();
        check_val("f_c3_valid", {31'd0, i_valid}, 32'd0);

        // Collision: data load wins, fetch granted at cycle 3
        pulse_reset();
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick();
        check_val("c_c1_m_addr", m_addr, 32'h100);
        tick();
        check_val("c_c2_d_valid", {31'd0, d_valid}, 32'd1);
        check_val("c_c2_d_rdata", d_rdata, 32'h1234_5678);
        check_val("c_c2_i_valid", {31'd0, i_valid}, 32'd0);
        d_req = 1'b0;
        tick();
        check_val("c_c3_d_valid", {31'd0, d_valid}, 32'd0);
        check_val("c_c3_i_valid", {31'd0, i_valid}, 32'd0);
        tick();
        check_val("c_c4_m_addr", m_addr, 32'h10);
        check_val("c_c4_i_valid", {31'd0, i_valid}, 32'd0);
        tick();
        check_val("c_c5_i_valid", {31'd0, i_valid}, 32'd1);
        check_val("c_c5_i_rdata", i_rdata, 32'h0050_0093);
        i_req = 1'b0;
        tick();
`ifdef MEM_ARB_PERF_CNT_EN
        check_val("perf_d_stall", perf_d_stall, 32'd2);
        check_val("perf_i_stall", perf_i_stall, 32'd5);
`endif

        // Store: one write pulse, d_rdata cleared to zero
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_byte_en = 4'h3;
        check_val("s_c0_m_we", {31'd0, m_we}, 32'd0);
        tick();
        check_val("s_c1_m_we", {31'd0, m_we}, 32'd1);
        check_val("s_c1_m_addr", m_addr, 32'h200);
        check_val("s_c1_m_wdata", m_wdata, 32'hDEAD_BEEF);
        check_val("s_c1_m_be", {28'd0, m_byte_en}, 32'h3);
        tick();
        check_val("s_c2_m_we", {31'd0, m_we}, 32'd0);
        check_val("s_c2_d_valid", {31'd0, d_valid}, 32'd1);
        check_val("s_c2_d_rdata", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check_val("s_c3_d_valid", {31'd0, d_valid}, 32'd0);
        check_val("s_c3_m_addr_hold", m_addr, 32'h200);

        // Starvation: both held high, fetch forced after four data grants
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        i_req = 1'b1; i_addr = 32'h10;
        for (int c = 1; c <= 200 && got_order.size() < 10; c++) begin
            tick();
            if (d_valid || i_valid) begin
                check_val("st_exclusive", {31'd0, d_valid & i_valid}, 32'd0);
                got_order.push_back(d_valid ? 1 : 0);
                got_cycle.push_back(c);
            end
        end
        check_val("st_count", got_order.size(), 32'd10);
        for (int k = 0; k < got_order.size() && k < 10; k++) begin
            check_val("st_order", got_order[k], exp_order[k]);
            check_val("st_cycle", got_cycle[k], 2 + 3 * k);
        end
        d_req = 1'b0; i_req = 1'b0;
        pulse_reset();

        // Reset during WAIT of a store; held request re-served after release
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h1122_3344; d_byte_en = 4'hF;
        tick();
        check_val("r_c1_m_we", {31'd0, m_we}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_val("r_c2_m_we", {31'd0, m_we}, 32'd0);
        check_val("r_c2_d_valid", {31'd0, d_valid}, 32'd0);
        check_val("r_c2_i_valid", {31'd0, i_valid}, 32'd0);
        check_val("r_c2_m_addr", m_addr, 32'h0);
        rst_n = 1'b1;
        tick();
        check_val("r_c3_m_we", {31'd0, m_we}, 32'd1);
        check_val("r_c3_d_valid", {31'd0, d_valid}, 32'd0);
        tick();
        check_val("r_c4_d_valid", {31'd0, d_valid}, 32'd1);
        check_val("r_c4_m_we", {31'd0, m_we}, 32'd0);
        d_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the load/store data port of the core.
- Latches the winning request, drives the memory for a fixed read latency, then returns read data with a one-cycle valid pulse to the owner.
- Data port has priority. A burst limit stops fetch starvation.
- Sits between the PC/fetch logic and load/store unit on one side and the memory instance on the other.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32 (byte enables are 4 bits)
- MEM_LATENCY, 1, cycles from address presented to m_rdata valid; legal range 1..7
- MAX_DATA_BURST, 4, consecutive data grants allowed while i_req is pending before fetch is forced

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request, level; held until i_valid
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch data, valid when i_valid
- i_valid  out  1  one-cycle completion pulse, fetch
- d_req  in  1  data request, level; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_byte_en  in  4  store byte enables
- d_rdata  out  DATA_W  load data, valid when d_valid
- d_valid  out  1  one-cycle completion pulse, data
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_we  out  1  memory write enable
- m_byte_en  out  4  memory byte enables
- m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset:
  - Synchronous, active-low: reset rst_n, synchronous, active-low; clock clk.
  - Reset forces state IDLE, burst counter 0, latency counter 0.
  - All outputs reset to 0.
  - An in-flight transaction is discarded with no valid pulse. Requesters re-present after release.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If d_req and not (i_req and burst_cnt == MAX_DATA_BURST): grant data.
  - Else if i_req: grant fetch.
  - On grant: latch owner, addr, we, wdata, byte_en; set lat_cnt = MEM_LATENCY; go to WAIT.
  - A fetch grant always has we = 0, byte_en = 4'hF.
- WAIT:
  - m_addr, m_wdata and m_byte_en are driven from the latched registers.
  - m_we = latched we only in the first WAIT cycle. Exactly one write pulse per store.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 1: capture m_rdata into the owner's rdata register (0 for stores), go to RESP.
- RESP:
  - Owner's valid = 1 for exactly one cycle; the other port's valid stays 0.
  - Requests are ignored in this cycle. Next state is IDLE.
  - A requester still asserting req in the cycle after its valid is treated as a new request.
- Latency and throughput:
  - Request sampled in IDLE at cycle N gives valid at cycle N + MEM_LATENCY + 1.
  - Peak throughput is one transaction per MEM_LATENCY + 2 cycles.
- Burst counter (saturating):
  - Increments on a data grant while i_req = 1.
  - Clears on any fetch grant, or on a data grant with i_req = 0.
- m_addr/m_wdata/m_byte_en in IDLE and RESP: hold the last latched values. m_we = 0.
- rdata registers hold their value until the next capture for that port.
- Request inputs change between grant and valid: ignored, since the transaction uses latched values.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_i_stall (32) and perf_d_stall (32).
  - Each counts cycles where its req = 1 and its valid = 0, saturating at 32'hFFFFFFFF.
  - Both are cleared by reset.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, WAIT, RESP}
  - owner_t enum {OWN_INSTR, OWN_DATA}
  - constant BYTE_EN_ALL = 4'hF
- No sub-module. FSM, counters and latches stay in one module of about 150–250 lines.

Test Plan (MEM_LATENCY = 1, MAX_DATA_BURST = 4):
- Fetch only: i_req = 1, i_addr = 0x10 at cycle 0; memory returns 0x00500093 → i_valid = 1 only at cycle 2, i_rdata = 0x00500093, m_we = 0 throughout, d_valid = 0.
- Collision: i_req and d_req (load 0x100, memory returns 0x12345678) both at cycle 0 → d_valid at cycle 2 with 0x12345678; fetch granted at cycle 3, i_valid at cycle 5.
- Store: d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, d_byte_en = 0x3 → m_we = 1 in cycle 1 only, m_addr = 0x200, m_byte_en = 0x3; d_valid at cycle 2 with d_rdata = 0.
- Starvation: d_req and i_req held high continuously → grant order D, D, D, D, I, D, D, D, D, I; no fetch waits longer than 5 transactions.
- Reset mid-op: rst_n = 0 during WAIT of a store → next cycle m_we = 0, both valids 0, state IDLE; after release the held d_req is re-served and valid arrives 2 cycles later.
- Perf (MEM_ARB_PERF_CNT_EN): run the collision scenario → perf_d_stall = 2, perf_i_stall = 5.
